// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multi-cycle controller for the 8x32 register file / ALU pair. One launch
// latches an instruction word, ALU control and repeat count, then runs
// read -> execute -> write-back iterations until the count is reached.
// Completion is reported with a busy level and a one-cycle done pulse.
//
// Build option: define ZERO_HALT_EN to end the run early after the first
// write-back whose captured ALU zero flag is set.
module alu_op_sequencer #(
   parameter int DW = 32,
   parameter int AW = 3,
   parameter int RW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [15:0]   instr,
   input  logic [2:0]    alu_op,
   input  logic [RW-1:0] rep,
   input  logic [DW-1:0] alu_res,
   input  logic          alu_zero,
   output logic [AW-1:0] addr_a,
   output logic [AW-1:0] addr_b,
   output logic [AW-1:0] addr_w,
   output logic          we_o,
   output logic [DW-1:0] wdata,
   output logic [2:0]    alu_ctr,
   output logic          a_sel,
   output logic          busy,
   output logic          done,
   output logic [RW-1:0] iter_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_EX,
      S_WB,
      S_DONE
   } state_t;

   state_t        state;
   logic          we_q;
   logic          zero_q;
   logic [RW-1:0] rep_q;
   logic [RW-1:0] iter_nxt;
   logic          halt;
   logic          unused_bits;

   // iteration count after the write-back in progress completes
   assign iter_nxt = iter_cnt + RW'(1);

`ifdef ZERO_HALT_EN
   // early termination on a zero result captured in EX
   assign halt        = zero_q;
   assign unused_bits = ^{instr[15:14], instr[11], instr[7], instr[3]};
`else
   // zero flag is still captured but never ends the run early
   assign halt        = 1'b0;
   assign unused_bits = ^{instr[15:14], instr[11], instr[7], instr[3], zero_q};
`endif

   // sequencer FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         addr_a   <= '0;
         addr_b   <= '0;
         addr_w   <= '0;
         alu_ctr  <= '0;
         a_sel    <= 1'b0;
         we_q     <= 1'b0;
         rep_q    <= '0;
         zero_q   <= 1'b0;
         wdata    <= '0;
         iter_cnt <= '0;
         we_o     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         // write enable and done are single-cycle pulses
         we_o <= 1'b0;
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  addr_a   <= AW'(instr[2:0]);
                  addr_b   <= AW'(instr[6:4]);
                  addr_w   <= AW'(instr[10:8]);
                  we_q     <= instr[12];
                  a_sel    <= instr[13];
                  alu_ctr  <= alu_op;
                  // a zero repeat count still runs one iteration
                  rep_q    <= (rep == '0) ? RW'(1) : rep;
                  iter_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= S_RD;
               end
            end
            S_RD: begin
               // register outputs and the ALU settle during this cycle
               state <= S_EX;
            end
            S_EX: begin
               wdata  <= alu_res;
               zero_q <= alu_zero;
               we_o   <= we_q;
               state  <= S_WB;
            end
            S_WB: begin
               iter_cnt <= iter_nxt;
               if ((iter_nxt == rep_q) || halt) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  state <= S_RD;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that drives the 8x32 register file and ALU pair automatically; replaces manual single-step write-back.
- Accepts one instruction word plus a repeat count, then runs read -> execute -> write-back iterations.
- Sits directly upstream of the register file and ALU. Drives read/write addresses, write enable, ALU control and the A-operand select. Consumes the ALU result and zero flag.
- Completion is signalled to the display/LED stage with a busy/done handshake.

Parameters:
- DW, 32, data width of ALU result and write data.
- AW, 3, register address width (8 registers).
- RW, 8, repeat-count width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch request; sampled only in IDLE.
- instr  input  16  [2:0] rs, [6:4] rt, [10:8] rd, [12] we, [13] a_sel, others reserved/ignored.
- alu_op  input  3  ALU control code, passed through unmodified.
- rep  input  RW  iteration count; 0 treated as 1.
- alu_res  input  DW  ALU result; combinational from current register outputs.
- alu_zero  input  1  ALU zero flag.
- addr_a  output  AW  register read port A address.
- addr_b  output  AW  register read port B address.
- addr_w  output  AW  register write address.
- we_o  output  1  register write enable.
- wdata  output  DW  write data (captured result).
- alu_ctr  output  3  latched ALU control.
- a_sel  output  1  latched A-operand mux select.
- busy  output  1  high from RD through WB.
- done  output  1  one-cycle completion pulse.
- iter_cnt  output  RW  iterations completed in the current/last run.

Behaviour:
- Reset: state=IDLE; all latched fields, wdata, iter_cnt = 0; we_o, busy, done = 0. This includes the address, control and select outputs.
- States: IDLE, RD, EX, WB, DONE.
- IDLE, start=1: latch instr fields, alu_op, rep (0 -> 1); clear iter_cnt; go RD. If start=0, stay.
- RD: one cycle for register read settling; go EX.
- EX: capture alu_res into wdata and alu_zero into zero_q; go WB.
- WB: we_o = latched we bit, for exactly this cycle; iter_cnt increments.
  - If the incremented iter_cnt equals the latched rep, go DONE; else go RD.
- DONE: done=1 for one cycle; go IDLE.
- Timing: start sampled at edge 0. First write is during cycle 3. Each further iteration adds 3 cycles. done is high in cycle 3*N+1.
- Address, control and select outputs hold the latched values from launch until the next launch. They do not track live instr/alu_op changes.
- start while busy or in DONE is ignored; there is no queueing.
- we bit = 0: iterations still run and wdata updates; we_o stays 0.
- iter_cnt holds its final value after DONE until the next launch.
- rst asserted mid-operation: at that edge go IDLE and clear everything. No write is issued in the reset cycle's successor, and done is not pulsed.
- rep at maximum (2^RW-1): the run completes without counter wrap.

Optional Feature:
- Macro: ZERO_HALT_EN.
- When defined: in WB, if zero_q=1 the sequencer goes to DONE after this write, regardless of the remaining count; iter_cnt shows the iterations actually executed.
- When undefined: alu_zero is ignored and exactly rep iterations always run.

Test Plan:
- Single add: R1=5, R2=3, instr rs=1 rt=2 rd=3 we=1, alu_op=add, rep=1, start pulse -> we_o high only in cycle 3, addr_w=3, wdata=8, done in cycle 4, busy cycles 1-3, iter_cnt=1.
- Accumulate: R3=0, R2=3, rs=3 rt=2 rd=3, add, rep=4 -> four write pulses at cycles 3/6/9/12 with wdata 3/6/9/12, done at cycle 13, iter_cnt=4.
- No-write and rep=0: we=0, rep=0 -> one iteration, we_o never high, wdata=result, done at cycle 4, iter_cnt=1.
- Start while busy: second start at cycle 2 with different instr -> ignored; addresses unchanged; only one done pulse.
- Reset mid-op: rst at cycle 5 of a rep=4 run -> next cycle state IDLE, busy=0, we_o=0, iter_cnt=0, no done pulse.
- ZERO_HALT_EN: R3=9, R2=3, sub, rs=3 rt=2 rd=3, rep=10 -> halts after 3 writes (6, 3, 0), done at cycle 10, iter_cnt=3. Without the macro -> 10 iterations run.
